// File: rtl/vend_state_reg_pkg.sv
// vend_pkg: vending-controller state encodings and default build values
// shared by the state register, its timeout counter, the bus interface
// and the testbench.
//
// state       | meaning
// ------------+------------------------------------------
// ST_IDLE     | waiting for a customer, reset/recovery
// ST_COIN5    | 5 units credited
// ST_COIN10   | 10 units credited
// ST_COIN15   | 15 units credited
// ST_COIN20   | 20 units credited
// ST_SELECT   | credit sufficient, waiting for selection
// ST_DISPENSE | product being dispensed
// ST_CHANGE   | returning change
// ST_REFUND   | returning full credit
// ST_SERVICE  | maintenance mode
package vend_pkg;

  localparam int VEND_WIDTH          = 4;
  localparam int VEND_NUM_STATES     = 10;
  localparam int VEND_TIMEOUT_CYCLES = 255;

  typedef enum logic [VEND_WIDTH-1:0] {
    ST_IDLE     = 4'd0,
    ST_COIN5    = 4'd1,
    ST_COIN10   = 4'd2,
    ST_COIN15   = 4'd3,
    ST_COIN20   = 4'd4,
    ST_SELECT   = 4'd5,
    ST_DISPENSE = 4'd6,
    ST_CHANGE   = 4'd7,
    ST_REFUND   = 4'd8,
    ST_SERVICE  = 4'd9
  } vend_state_e;

endpackage

// File: rtl/vend_state_reg_if.sv
// vend_state_reg_if: request/status bundle of the vending state register.
//   master : drives load/newState/clear/error_clr, observes status
//   slave  : the state register itself
interface vend_state_reg_if
  import vend_pkg::*;
#(
  parameter int WIDTH = VEND_WIDTH
);
  logic             load;
  logic [WIDTH-1:0] newState;
  logic             clear;
  logic             error_clr;
  logic [WIDTH-1:0] state;
  logic [WIDTH-1:0] prevState;
  logic             changed;
  logic             timeout;
  logic             illegal;

  modport master (
    output load, newState, clear, error_clr,
    input  state, prevState, changed, timeout, illegal
  );

  modport slave (
    input  load, newState, clear, error_clr,
    output state, prevState, changed, timeout, illegal
  );
endinterface

// File: rtl/vend_state_reg_timeout_ctr.sv
// state_timeout_ctr: saturating idle-edge counter for the state register.
// Ports:
//   clk    falling-edge clock
//   reset  async active-low reset
//   run    count this edge
//   zero   clear the count this edge (wins over run)
//   expire count has reached TIMEOUT_CYCLES-1 (or saturated past it);
//          the next uninterrupted edge is the timeout edge
module state_timeout_ctr
  import vend_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = VEND_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  input  logic zero,
  output logic expire
);

  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = (TIMEOUT_CYCLES > 0) ? CW'(TIMEOUT_CYCLES - 1) : '0;

  logic [CW-1:0] cnt_q, cnt_d;

  // Saturate at TIMEOUT_CYCLES: an illegal load on the expiry edge blocks
  // the timeout but still counts, so the count may step one past LAST.
  always_comb begin
    cnt_d = cnt_q;
    if (zero)
      cnt_d = '0;
    else if (run && (cnt_q != CNT_MAX))
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(negedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign expire = (TIMEOUT_CYCLES > 0) && ((cnt_q == CNT_LAST) || (cnt_q == CNT_MAX));

endmodule

// File: rtl/vend_state_reg.sv
// vend_state_reg: vending-controller state register with previous-state
// capture, change/timeout pulses and a sticky illegal-request flag.
// All registers update on the falling edge of clk.
// Ports:
//   clk    clock (falling edge active)
//   reset  async active-low reset
//   bus    vend_state_reg_if.slave: load/newState/clear/error_clr in,
//          state/prevState/changed/timeout/illegal out (all registered)
// Per-edge priority: clear > illegal load > legal load > timeout > hold.
module vend_state_reg
  import vend_pkg::*;
#(
  parameter int WIDTH          = VEND_WIDTH,
  parameter int NUM_STATES     = VEND_NUM_STATES,
  parameter int IDLE_STATE     = int'(ST_IDLE),
  parameter int TIMEOUT_CYCLES = VEND_TIMEOUT_CYCLES
) (
  input  logic              clk,
  input  logic              reset,
  vend_state_reg_if.slave   bus
);

  if (NUM_STATES > 2 ** WIDTH) begin : g_bad_num_states
    $error("vend_state_reg: NUM_STATES exceeds 2**WIDTH");
  end
  if (IDLE_STATE >= NUM_STATES) begin : g_bad_idle_state
    $error("vend_state_reg: IDLE_STATE must be below NUM_STATES");
  end

  localparam logic [WIDTH-1:0] IDLE_W = WIDTH'(IDLE_STATE);
  localparam logic [WIDTH:0]   NUM_W  = (WIDTH + 1)'(NUM_STATES);

  logic [WIDTH-1:0] state_q, state_d, prev_q;
  logic             changed_q, timeout_q, illegal_q;
  logic             legal, ld_ok, ld_bad, fire, expire, tmr_zero, tmr_run;

  assign legal  = {1'b0, bus.newState} < NUM_W;
  assign ld_ok  = bus.load & ~bus.clear & legal;
  assign ld_bad = bus.load & ~bus.clear & ~legal;
  // Any load, even a rejected one, pre-empts the timeout on this edge.
  assign fire   = expire & ~bus.load & ~bus.clear & (state_q != IDLE_W);

  assign tmr_zero = bus.clear | ld_ok | fire | (state_q == IDLE_W) | (TIMEOUT_CYCLES == 0);
  assign tmr_run  = ~tmr_zero;

  state_timeout_ctr #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout_ctr (
    .clk   (clk),
    .reset (reset),
    .run   (tmr_run),
    .zero  (tmr_zero),
    .expire(expire)
  );

  always_comb begin
    state_d = state_q;
    if (bus.clear)
      state_d = IDLE_W;
    else if (ld_ok)
      state_d = bus.newState;
    else if (fire)
      state_d = IDLE_W;
  end

  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE_W;
      prev_q    <= IDLE_W;
      changed_q <= 1'b0;
      timeout_q <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      changed_q <= (state_d != state_q);
      timeout_q <= fire;
      if (state_d != state_q)
        prev_q <= state_q;
      if (ld_bad)
        illegal_q <= 1'b1;
      else if (bus.error_clr)
        illegal_q <= 1'b0;
    end
  end

  assign bus.state     = state_q;
  assign bus.prevState = prev_q;
  assign bus.changed   = changed_q;
  assign bus.timeout   = timeout_q;
  assign bus.illegal   = illegal_q;

endmodule
